point_packetizer: RTL and testbench



---
 rtl/point_packetizer.sv | 174 +++++++++++++++++
 tb/tb_point_packetizer.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/point_packetizer.sv
// point_packetizer
//
// Turns one laser point into a 23-byte point-update Ethernet frame. The frame
// is written byte-serially into the transmit packet buffer, and then the
// doorbell is pulsed so display_controller can read bytes 14..22.
//
// Handshake: a point transfers on a rising clock edge where
// point_valid_in && point_ready_out. point_ready_out is high only while the
// block is idle and the transmit path is not busy. All point fields are
// captured at that edge, so later input changes have no effect on the packet
// in flight.
//
// Ports
//   clock_in, reset_in        clock, asynchronous active-low reset
//   point_*_in / point_ready_out  point handshake and payload
//   tx_busy_in                holds off acceptance while the MAC drains
//   pkt_addr_out/data/we      packet buffer byte write port
//   pkt_buf_doorbell_out      one-cycle pulse after byte 22 is written
//   pkt_count_out             packets sent (wraps)
//   frame_count_out           bank-swap packets sent (wraps)
//   state_out                 current FSM state, for debug and checkers
module point_packetizer #(
  parameter logic [47:0] DST_MAC   = 48'hFF_FF_FF_FF_FF_FF,
  parameter logic [47:0] SRC_MAC   = 48'h02_00_00_00_00_01,
  parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
  input  logic        clock_in,
  input  logic        reset_in,
  input  logic        point_valid_in,
  output logic        point_ready_out,
  input  logic [15:0] point_x_in,
  input  logic [15:0] point_y_in,
  input  logic [7:0]  point_r_in,
  input  logic [7:0]  point_g_in,
  input  logic [7:0]  point_b_in,
  input  logic        point_last_in,
  input  logic        tx_busy_in,
  output logic [10:0] pkt_addr_out,
  output logic [7:0]  pkt_data_out,
  output logic        pkt_we_out,
  output logic        pkt_buf_doorbell_out,
  output logic [15:0] pkt_count_out,
  output logic [15:0] frame_count_out,
  output logic [1:0]  state_out
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WRITE    = 2'd1,
    DOORBELL = 2'd2
  } state_t;

  localparam logic [4:0] FRAME_LEN = 5'd23;

  state_t      state_q;
  logic        idle_q;      // registered "ready to accept" qualifier
  logic [4:0]  byte_idx_q;  // index of the next byte to emit
  logic [15:0] x_q, y_q;
  logic [7:0]  r_q, g_q, b_q;
  logic        last_q;
  logic [15:0] pkt_count_q, frame_count_q;
  logic [7:0]  frame_byte;
  logic        accept;

  // Ready follows tx_busy_in combinationally while idle so that dropping
  // busy lets a waiting point in on the very next edge. idle_q is low in
  // reset, so ready only rises after the first edge following release.
  assign point_ready_out = idle_q && !tx_busy_in;
  assign accept          = point_valid_in && point_ready_out;

  assign pkt_count_out   = pkt_count_q;
  assign frame_count_out = frame_count_q;
  assign state_out       = state_q;

  // Frame layout, multi-byte fields MSB first.
  always_comb begin
    frame_byte = 8'h00;
    case (byte_idx_q)
      5'd0:  frame_byte = DST_MAC[47:40];
      5'd1:  frame_byte = DST_MAC[39:32];
      5'd2:  frame_byte = DST_MAC[31:24];
      5'd3:  frame_byte = DST_MAC[23:16];
      5'd4:  frame_byte = DST_MAC[15:8];
      5'd5:  frame_byte = DST_MAC[7:0];
      5'd6:  frame_byte = SRC_MAC[47:40];
      5'd7:  frame_byte = SRC_MAC[39:32];
      5'd8:  frame_byte = SRC_MAC[31:24];
      5'd9:  frame_byte = SRC_MAC[23:16];
      5'd10: frame_byte = SRC_MAC[15:8];
      5'd11: frame_byte = SRC_MAC[7:0];
      5'd12: frame_byte = ETHERTYPE[15:8];
      5'd13: frame_byte = ETHERTYPE[7:0];
      5'd14: frame_byte = last_q ? 8'h02 : 8'h01;  // bank swap vs point
      5'd15: frame_byte = x_q[15:8];
      5'd16: frame_byte = x_q[7:0];
      5'd17: frame_byte = y_q[15:8];
      5'd18: frame_byte = y_q[7:0];
      5'd19: frame_byte = r_q;
      5'd20: frame_byte = g_q;
      5'd21: frame_byte = b_q;
      default: frame_byte = 8'h00;  // byte 22 is reserved
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q              <= IDLE;
      idle_q               <= 1'b0;
      byte_idx_q           <= 5'd0;
      x_q                  <= 16'h0000;
      y_q                  <= 16'h0000;
      r_q                  <= 8'h00;
      g_q                  <= 8'h00;
      b_q                  <= 8'h00;
      last_q               <= 1'b0;
      pkt_addr_out         <= 11'd0;
      pkt_data_out         <= 8'h00;
      pkt_we_out           <= 1'b0;
      pkt_buf_doorbell_out <= 1'b0;
      pkt_count_q          <= 16'h0000;
      frame_count_q        <= 16'h0000;
    end else begin
      case (state_q)
        IDLE: begin
          pkt_buf_doorbell_out <= 1'b0;
          pkt_we_out           <= 1'b0;
          idle_q               <= 1'b1;
          if (accept) begin
            x_q    <= point_x_in;
            y_q    <= point_y_in;
            r_q    <= point_r_in;
            g_q    <= point_g_in;
            b_q    <= point_b_in;
            last_q <= point_last_in;
            idle_q <= 1'b0;
            // Byte 0 goes out on the accept edge; it never depends on the
            // point fields, so the not-yet-latched registers are irrelevant.
            pkt_we_out   <= 1'b1;
            pkt_addr_out <= 11'd0;
            pkt_data_out <= DST_MAC[47:40];
            byte_idx_q   <= 5'd1;
            state_q      <= WRITE;
          end
        end
        WRITE: begin
          if (byte_idx_q == FRAME_LEN) begin
            pkt_we_out           <= 1'b0;
            pkt_buf_doorbell_out <= 1'b1;
            pkt_count_q          <= pkt_count_q + 16'd1;
            if (last_q) frame_count_q <= frame_count_q + 16'd1;
            state_q              <= DOORBELL;
          end else begin
            pkt_we_out   <= 1'b1;
            pkt_addr_out <= {6'd0, byte_idx_q};
            pkt_data_out <= frame_byte;
            byte_idx_q   <= byte_idx_q + 5'd1;
          end
        end
        DOORBELL: begin
          pkt_buf_doorbell_out <= 1'b0;
          idle_q               <= 1'b1;
          state_q              <= IDLE;
        end
        default: begin
          pkt_we_out           <= 1'b0;
          pkt_buf_doorbell_out <= 1'b0;
          idle_q               <= 1'b0;
          state_q              <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_point_packetizer.sv
// Bench for point_packetizer: directed points, a frame-level reference model
// checked every cycle, and hand-computed literal expectations.
module tb_point_packetizer;

  localparam logic [47:0] DST_MAC   = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] SRC_MAC   = 48'h02_00_00_00_00_01;
  localparam logic [15:0] ETHERTYPE = 16'h88B5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic        point_valid_in = 1'b0;
  logic        point_ready_out;
  logic [15:0] point_x_in = '0, point_y_in = '0;
  logic [7:0]  point_r_in = '0, point_g_in = '0, point_b_in = '0;
  logic        point_last_in = 1'b0;
  logic        tx_busy_in = 1'b0;
  logic [10:0] pkt_addr_out;
  logic [7:0]  pkt_data_out;
  logic        pkt_we_out;
  logic        pkt_buf_doorbell_out;
  logic [15:0] pkt_count_out, frame_count_out;
  logic [1:0]  state_out;

  point_packetizer dut (
    .clock_in            (clk),
    .reset_in            (rst_n),
    .point_valid_in      (point_valid_in),
    .point_ready_out     (point_ready_out),
    .point_x_in          (point_x_in),
    .point_y_in          (point_y_in),
    .point_r_in          (point_r_in),
    .point_g_in          (point_g_in),
    .point_b_in          (point_b_in),
    .point_last_in       (point_last_in),
    .tx_busy_in          (tx_busy_in),
    .pkt_addr_out        (pkt_addr_out),
    .pkt_data_out        (pkt_data_out),
    .pkt_we_out          (pkt_we_out),
    .pkt_buf_doorbell_out(pkt_buf_doorbell_out),
    .pkt_count_out       (pkt_count_out),
    .frame_count_out     (frame_count_out),
    .state_out           (state_out)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // ---------------- reference model ----------------
  // A frame is a list of 23 bytes; the model replays it one byte per cycle,
  // then one doorbell cycle, then returns to accepting.
  logic [7:0]  exp_q[$];
  logic        m_idle = 1'b0, m_we = 1'b0, m_db = 1'b0, m_last = 1'b0;
  logic [10:0] m_addr = '0;
  logic [7:0]  m_data = '0;
  logic [15:0] m_pkt = '0, m_frm = '0;

  logic [7:0]  mem [0:2047];
  int we_count = 0, db_count = 0, db_cyc = 0;

  task automatic build_frame();
    exp_q.delete();
    for (int i = 5; i >= 0; i--) exp_q.push_back(8'(DST_MAC >> (8 * i)));
    for (int i = 5; i >= 0; i--) exp_q.push_back(8'(SRC_MAC >> (8 * i)));
    exp_q.push_back(ETHERTYPE[15:8]);
    exp_q.push_back(ETHERTYPE[7:0]);
    exp_q.push_back(point_last_in ? 8'h02 : 8'h01);
    exp_q.push_back(point_x_in[15:8]);
    exp_q.push_back(point_x_in[7:0]);
    exp_q.push_back(point_y_in[15:8]);
    exp_q.push_back(point_y_in[7:0]);
    exp_q.push_back(point_r_in);
    exp_q.push_back(point_g_in);
    exp_q.push_back(point_b_in);
    exp_q.push_back(8'h00);
  endtask

  // Compare process: inputs only change just after a rising edge, so at the
  // falling edge they already hold what the DUT samples at the next edge.
  always begin
    @(negedge clk);
    if (!rst_n) begin
      check("rst_ready", point_ready_out, 0);
      check("rst_we",    pkt_we_out, 0);
      check("rst_addr",  pkt_addr_out, 0);
      check("rst_data",  pkt_data_out, 0);
      check("rst_db",    pkt_buf_doorbell_out, 0);
      check("rst_pkt",   pkt_count_out, 0);
      check("rst_frm",   frame_count_out, 0);
      exp_q.delete();
      m_idle = 0; m_we = 0; m_db = 0; m_last = 0;
      m_pkt = 0; m_frm = 0;
    end else begin
      check("ready",     point_ready_out, m_idle && !tx_busy_in);
      check("we",        pkt_we_out, m_we);
      check("doorbell",  pkt_buf_doorbell_out, m_db);
      check("pkt_count", pkt_count_out, m_pkt);
      check("frm_count", frame_count_out, m_frm);
      if (m_we) begin
        check("addr", pkt_addr_out, m_addr);
        check("data", pkt_data_out, m_data);
      end
      if (pkt_we_out) begin
        mem[pkt_addr_out] = pkt_data_out;
        we_count++;
      end
      if (pkt_buf_doorbell_out) begin
        db_count++;
        db_cyc = cyc;
      end
      // advance the model to the next cycle
      if (exp_q.size() > 0) begin
        m_addr = 11'(23 - exp_q.size());
        m_data = exp_q.pop_front();
        m_we = 1;
      end else if (m_we) begin
        m_we = 0;
        m_db = 1;
        m_pkt = m_pkt + 16'd1;
        if (m_last) m_frm = m_frm + 16'd1;
      end else if (m_db) begin
        m_db = 0;
        m_idle = 1;
      end else if (!m_idle) begin
        m_idle = 1;  // first edge after reset release
      end else if (!tx_busy_in && point_valid_in) begin
        build_frame();
        m_last = point_last_in;
        m_addr = 11'd0;
        m_data = exp_q.pop_front();
        m_we = 1;
        m_idle = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic after_edge(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    after_edge(1);
    rst_n = 0;
    after_edge(2);
    rst_n = 1;
  endtask

  // Presents a point and returns once accepted; valid stays high. acc is the
  // cycle number holding the first write (cycle T0+1 for accept edge T0).
  task automatic send_point(input logic [15:0] x, input logic [15:0] y,
                            input logic [7:0] r, input logic [7:0] g,
                            input logic [7:0] b, input logic last,
                            output int acc);
    point_x_in = x; point_y_in = y;
    point_r_in = r; point_g_in = g; point_b_in = b;
    point_last_in = last;
    point_valid_in = 1;
    acc = -1;
    for (int i = 0; i < 300 && acc < 0; i++) begin
      @(negedge clk);
      if (point_ready_out) begin
        @(posedge clk);
        #1;
        acc = cyc;
      end
    end
    if (acc < 0) timeout("accept");
  endtask

  task automatic wait_doorbells(input int target, input int budget);
    int n;
    n = 0;
    while (db_count < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (db_count < target) timeout("doorbell");
    #1;
  endtask

  // ---------------- directed tests ----------------
  int acc;
  int accs[7];
  int base_db, base_we, n;

  initial begin
    #1 rst_n = 0;
    after_edge(3);
    rst_n = 1;
    check("ready_before_edge", point_ready_out, 0);
    after_edge(1);
    check("ready_after_edge", point_ready_out, 1);

    // Test 1: single point, all payload bytes 01
    base_we = we_count;
    send_point(16'h0101, 16'h0101, 8'h01, 8'h01, 8'h01, 1'b0, acc);
    point_valid_in = 0;
    wait_doorbells(1, 60);
    check("t1_writes", we_count - base_we, 23);
    check("t1_db_cycle", db_cyc, acc + 23);
    check("t1_byte0", mem[0], 8'hFF);
    check("t1_byte6", mem[6], 8'h02);
    check("t1_byte11", mem[11], 8'h01);
    check("t1_byte12", mem[12], 8'h88);
    check("t1_byte13", mem[13], 8'hB5);
    check("t1_cmd", mem[14], 8'h01);
    for (int i = 15; i <= 21; i++) check("t1_payload", mem[i], 8'h01);
    check("t1_byte22", mem[22], 8'h00);
    check("t1_pkt", pkt_count_out, 1);
    check("t1_frm", frame_count_out, 0);

    // Test 2: six points then a bank swap, valid held high throughout
    pulse_reset();
    base_db = db_count;
    for (int i = 1; i <= 6; i++)
      send_point(16'(i), 16'(i), 8'(i), 8'(i), 8'(i), 1'b0, accs[i-1]);
    send_point(16'hFFFF, 16'hFFFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, accs[6]);
    point_valid_in = 0;
    wait_doorbells(base_db + 7, 100);
    check("t2_doorbells", db_count - base_db, 7);
    check("t2_spacing", accs[6] - accs[0], 150);
    check("t2_cmd", mem[14], 8'h02);
    check("t2_x_hi", mem[15], 8'hFF);
    check("t2_b", mem[21], 8'hFF);
    check("t2_pkt", pkt_count_out, 7);
    check("t2_frm", frame_count_out, 1);

    // Test 3: busy holds off acceptance; dropping busy starts on next edge
    tx_busy_in = 1;
    point_x_in = 16'hAAAA; point_last_in = 0;
    point_valid_in = 1;
    base_we = we_count;
    after_edge(100);
    check("t3_no_writes", we_count - base_we, 0);
    check("t3_ready_low", point_ready_out, 0);
    tx_busy_in = 0;
    after_edge(1);
    point_valid_in = 0;
    check("t3_start_we", pkt_we_out, 1);
    check("t3_start_addr", pkt_addr_out, 0);
    wait_doorbells(base_db + 8, 60);
    check("t3_x_hi", mem[15], 8'hAA);

    // Test 4: inputs change and busy rises mid-packet
    send_point(16'h1234, 16'h5678, 8'h9A, 8'hBC, 8'hDE, 1'b0, acc);
    after_edge(5);
    point_x_in = 16'h0F0F; point_y_in = 16'hF0F0;
    point_r_in = 8'h11; point_g_in = 8'h22; point_b_in = 8'h33;
    point_last_in = 1;
    tx_busy_in = 1;
    wait_doorbells(base_db + 9, 60);
    point_valid_in = 0;
    tx_busy_in = 0;
    check("t4_cmd", mem[14], 8'h01);
    check("t4_x_hi", mem[15], 8'h12);
    check("t4_x_lo", mem[16], 8'h34);
    check("t4_y_hi", mem[17], 8'h56);
    check("t4_y_lo", mem[18], 8'h78);
    check("t4_r", mem[19], 8'h9A);
    check("t4_g", mem[20], 8'hBC);
    check("t4_b", mem[21], 8'hDE);
    check("t4_frm", frame_count_out, 1);

    // Test 5: reset while byte 10 is being written
    send_point(16'h4444, 16'h5555, 8'h66, 8'h77, 8'h88, 1'b0, acc);
    point_valid_in = 0;
    n = 0;
    while (!(pkt_we_out && pkt_addr_out == 11'd10) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) timeout("byte10");
    #1 rst_n = 0;
    #1;
    check("t5_we", pkt_we_out, 0);
    check("t5_addr", pkt_addr_out, 0);
    check("t5_data", pkt_data_out, 0);
    check("t5_db", pkt_buf_doorbell_out, 0);
    check("t5_pkt", pkt_count_out, 0);
    check("t5_ready", point_ready_out, 0);
    base_db = db_count;
    after_edge(3);
    rst_n = 1;
    after_edge(30);
    check("t5_no_db", db_count - base_db, 0);
    base_we = we_count;
    send_point(16'h0102, 16'h0304, 8'h05, 8'h06, 8'h07, 1'b0, acc);
    point_valid_in = 0;
    wait_doorbells(base_db + 1, 60);
    check("t5_writes", we_count - base_we, 23);
    check("t5_pkt_after", pkt_count_out, 1);
    check("t5_y_lo", mem[18], 8'h04);

    // Test 6: packet counter wrap, preloaded by force while idle
    after_edge(1);
    force dut.pkt_count_q = 16'hFFFE;
    m_pkt = 16'hFFFE;
    #1 release dut.pkt_count_q;
    base_db = db_count;
    send_point(16'h0001, 16'h0002, 8'h03, 8'h04, 8'h05, 1'b0, acc);
    point_valid_in = 0;
    wait_doorbells(base_db + 1, 60);
    check("t6_pkt_ffff", pkt_count_out, 16'hFFFF);
    send_point(16'h0001, 16'h0002, 8'h03, 8'h04, 8'h05, 1'b0, acc);
    point_valid_in = 0;
    wait_doorbells(base_db + 2, 60);
    check("t6_pkt_wrap", pkt_count_out, 16'h0000);

    after_edge(5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
